// File: rtl/mem_lsu.sv
// Memory-stage load/store unit with a req/gnt/rvalid data port and MEM/WB register.
// Optional misaligned-access trap: define MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] opr_res,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [4:0]            rd,
    input  logic [DATA_WIDTH-1:0] pc4,
    input  logic                  rf_en,
    input  logic                  dm_en,
    input  logic [1:0]            wb_sel,
    input  logic [3:0]            lsuop,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [DATA_WIDTH-1:0] dm_addr,
    output logic [BE_WIDTH-1:0]   dm_be,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic                  dm_gnt,
    input  logic                  dm_rvalid,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic                  wb_rf_en,
    output logic [1:0]            wb_sel_o,
    output logic [DATA_WIDTH-1:0] wb_opr_res,
    output logic [DATA_WIDTH-1:0] wb_pc4,
    output logic [DATA_WIDTH-1:0] wb_lsu_rdata,
    output logic                  lsu_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] l_res, l_b, l_pc4;
    logic [4:0]            l_rd;
    logic                  l_rf_en;
    logic [1:0]            l_sel;
    logic [3:0]            l_op;

    logic [DATA_WIDTH-1:0] c_res, c_b, c_pc4;
    logic [4:0]            c_rd;
    logic                  c_rf_en;
    logic [1:0]            c_sel;
    logic [3:0]            c_op;

    logic                  access, is_st, is_b, is_h, is_w, sgn, mis;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] sh, ext;

    logic cap, cap_v, mis_hit, load_done;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Snapshot the execute bundle while idle; it is authoritative once stalled
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            l_res   <= '0;
            l_b     <= '0;
            l_pc4   <= '0;
            l_rd    <= '0;
            l_rf_en <= 1'b0;
            l_sel   <= '0;
            l_op    <= '0;
        end else if (state == S_IDLE) begin
            l_res   <= opr_res;
            l_b     <= opr_b;
            l_pc4   <= pc4;
            l_rd    <= rd;
            l_rf_en <= rf_en;
            l_sel   <= wb_sel;
            l_op    <= lsuop;
        end
    end

    // Select live inputs in IDLE, latched copy otherwise
    always_comb begin
        c_res   = opr_res;
        c_b     = opr_b;
        c_pc4   = pc4;
        c_rd    = rd;
        c_rf_en = rf_en;
        c_sel   = wb_sel;
        c_op    = lsuop;
        if (state != S_IDLE) begin
            c_res   = l_res;
            c_b     = l_b;
            c_pc4   = l_pc4;
            c_rd    = l_rd;
            c_rf_en = l_rf_en;
            c_sel   = l_sel;
            c_op    = l_op;
        end
    end

    assign access = in_valid & dm_en;
    assign is_st  = c_op[3];
    assign is_b   = (c_op[1:0] == 2'b00);
    assign is_h   = (c_op[1:0] == 2'b01);
    assign is_w   = ~is_b & ~is_h;
    assign sgn    = ~c_op[2];

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign mis = (is_h & c_res[0]) | (is_w & (|c_res[1:0]));
`else
    assign mis = 1'b0;
`endif

    // Byte lanes, store data replication and load extraction
    always_comb begin
        off      = 2'b00;
        dm_be    = '1;
        dm_wdata = c_b;
        unique case (1'b1)
            is_b: begin
                off      = c_res[1:0];
                dm_be    = {{(BE_WIDTH-1){1'b0}}, 1'b1} << off;
                dm_wdata = {BE_WIDTH{c_b[7:0]}};
            end
            is_h: begin
                off      = {c_res[1], 1'b0};
                dm_be    = {{(BE_WIDTH-2){1'b0}}, 2'b11} << off;
                dm_wdata = {(BE_WIDTH/2){c_b[15:0]}};
            end
            default: ;
        endcase
        sh  = dm_rdata >> {off, 3'b000};
        ext = sh;
        unique case (1'b1)
            is_b:    ext = {{(DATA_WIDTH-8){sgn & sh[7]}}, sh[7:0]};
            is_h:    ext = {{(DATA_WIDTH-16){sgn & sh[15]}}, sh[15:0]};
            default: ;
        endcase
    end

    assign dm_addr = {c_res[DATA_WIDTH-1:2], 2'b00};
    assign dm_we   = dm_req & is_st;

    // Next state, request, stall and writeback capture
    always_comb begin
        state_nx  = state;
        dm_req    = 1'b0;
        stall     = 1'b0;
        cap       = 1'b0;
        cap_v     = 1'b1;
        mis_hit   = 1'b0;
        load_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!access) begin
                    cap   = 1'b1;
                    cap_v = in_valid;
                end else if (mis) begin
                    cap     = 1'b1;
                    mis_hit = 1'b1;
                end else begin
                    dm_req = 1'b1;
                    if (is_st && dm_gnt) begin
                        cap = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = (dm_gnt && !is_st) ? S_WAIT : S_REQ;
                    end
                end
            end
            S_REQ: begin
                dm_req = 1'b1;
                if (dm_gnt && is_st) begin
                    cap      = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (dm_gnt) state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dm_rvalid) begin
                    cap       = 1'b1;
                    load_done = 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // MEM/WB register; bubbles leave the payload untouched
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_rf_en     <= 1'b0;
            wb_sel_o     <= '0;
            wb_opr_res   <= '0;
            wb_pc4       <= '0;
            wb_lsu_rdata <= '0;
            lsu_misalign <= 1'b0;
        end else begin
            wb_valid     <= cap & cap_v;
            lsu_misalign <= cap & mis_hit;
            if (cap && cap_v) begin
                wb_rd        <= c_rd;
                wb_rf_en     <= c_rf_en & ~mis_hit;
                wb_sel_o     <= c_sel;
                wb_opr_res   <= c_res;
                wb_pc4       <= c_pc4;
                wb_lsu_rdata <= load_done ? ext : '0;
            end
        end
    end

endmodule
